// File: rtl/spin_strip_renderer_if.sv
// Control handshake between a spin requester and the strip renderer.
interface spin_strip_renderer_if;
    logic       start;
    logic [2:0] seed;
    logic       busy;
    logic       done;
    logic [2:0] result;

    modport master (output start, output seed, input busy, input done, input result);
    modport slave  (input start, input seed, output busy, output done, output result);
endinterface

// File: rtl/spin_strip_renderer.sv
// Pixel-content generator for the VGA output stage: draws an 8-tile strip
// with a highlight cursor, and runs a frame-paced spin that accelerates
// the cursor, decelerates it, then stops on a result tile.
module spin_strip_renderer #(
    parameter int unsigned STRIP_X0   = 64,
    parameter int unsigned STRIP_Y0   = 208,
    parameter int unsigned FAST_STEPS = 24,
    parameter int unsigned SLOW_STEPS = 8,
    parameter int unsigned PERIOD_MIN = 2,
    parameter logic [5:0]  BG_COLOR   = 6'b010000,
    parameter logic [47:0] PALETTE    = {6'b101010, 6'b010101, 6'b110011, 6'b111100,
                                         6'b001111, 6'b110000, 6'b001100, 6'b000011}
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [9:0]            horCnt,
    input  logic [9:0]            verCnt,
    input  logic                  sActive,
    output logic [5:0]            rgbContent,
    spin_strip_renderer_if.slave  ctrl
);

    localparam logic [9:0] X0 = 10'(STRIP_X0);
    localparam logic [9:0] X1 = 10'(STRIP_X0 + 512);
    localparam logic [9:0] Y0 = 10'(STRIP_Y0);
    localparam logic [9:0] Y1 = 10'(STRIP_Y0 + 64);

    typedef enum logic [1:0] {IDLE, SPIN, SLOW, DONE} state_t;

    state_t     state, stateNxt;
    logic [2:0] cursor, cursorNxt;
    logic [2:0] resultReg, resultNxt;
    logic [7:0] frameCnt, frameCntNxt;
    logic [7:0] stepsLeft, stepsLeftNxt;
    logic [7:0] period, periodNxt;
    logic [7:0] stepsDec;
    logic       tick;

    // Pixel path signals
    logic       inStrip;
    logic [2:0] tileIdx;
    logic [5:0] locX, locY;
    logic       border;
    logic [5:0] palEntry;
    logic [5:0] pixNxt;

    // First blanking line marks one frame
    assign tick = (verCnt == 10'd480) && (horCnt == 10'd0);

    assign ctrl.busy   = (state == SPIN) || (state == SLOW);
    assign ctrl.done   = (state == DONE);
    assign ctrl.result = resultReg;

    // Spin state and datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cursor    <= '0;
            resultReg <= '0;
            frameCnt  <= '0;
            stepsLeft <= '0;
            period    <= '0;
        end else begin
            state     <= stateNxt;
            cursor    <= cursorNxt;
            resultReg <= resultNxt;
            frameCnt  <= frameCntNxt;
            stepsLeft <= stepsLeftNxt;
            period    <= periodNxt;
        end
    end

    // Next-state: start capture in IDLE/DONE, frame-paced stepping while spinning
    always_comb begin
        stateNxt     = state;
        cursorNxt    = cursor;
        resultNxt    = resultReg;
        frameCntNxt  = frameCnt;
        stepsLeftNxt = stepsLeft;
        periodNxt    = period;
        stepsDec     = stepsLeft - 8'd1;
        unique case (state)
            IDLE, DONE: begin
                if (ctrl.start) begin
                    stateNxt     = SPIN;
                    stepsLeftNxt = 8'(FAST_STEPS) + {5'b0, ctrl.seed} + 8'(SLOW_STEPS);
                    periodNxt    = 8'(PERIOD_MIN);
                    frameCntNxt  = '0;
                end
            end
            SPIN, SLOW: begin
                if (tick) begin
                    if (frameCnt + 8'd1 == period) begin
                        cursorNxt    = cursor + 3'd1;
                        frameCntNxt  = '0;
                        stepsLeftNxt = stepsDec;
                        if (state == SPIN) begin
                            if (stepsDec == 8'(SLOW_STEPS)) begin
                                stateNxt  = SLOW;
                                periodNxt = 8'(PERIOD_MIN + 1);
                            end
                        end else if (stepsDec == '0) begin
                            stateNxt  = DONE;
                            resultNxt = cursor + 3'd1;
                        end else begin
                            periodNxt = period + 8'd1;
                        end
                    end else begin
                        frameCntNxt = frameCnt + 8'd1;
                    end
                end
            end
            default: stateNxt = IDLE;
        endcase
    end

    assign inStrip = (horCnt >= X0) && (horCnt < X1) && (verCnt >= Y0) && (verCnt < Y1);
    assign {tileIdx, locX} = 9'(horCnt - X0);
    assign locY = 6'(verCnt - Y0);
    assign border = (locX == 6'd0) || (locX == 6'd63) || (locY == 6'd0) || (locY == 6'd63);

    // Pixel colour selection for the current counter position
    always_comb begin
        palEntry = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (tileIdx == 3'(i)) palEntry = PALETTE[6*i +: 6];
        end
        if (!sActive)               pixNxt = '0;
        else if (!inStrip)          pixNxt = BG_COLOR;
        else if (border)            pixNxt = '0;
        else if (tileIdx == cursor) pixNxt = '1;
        else                        pixNxt = palEntry;
    end

    // One-cycle registered pixel output
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rgbContent <= '0;
        else        rgbContent <= pixNxt;
    end

endmodule

// File: tb/tb_spin_strip_renderer.sv
// Scoreboard bench for spin_strip_renderer: stimulus pushes expected pixels
// and spin outcomes; a monitor pops and compares as the DUT produces them.
module tb_spin_strip_renderer;

    localparam logic [5:0] COL0 = 6'b000011;
    localparam logic [5:0] COL1 = 6'b001100;
    localparam logic [5:0] COL2 = 6'b110000;
    localparam logic [5:0] COL3 = 6'b001111;
    localparam logic [5:0] COL4 = 6'b111100;
    localparam logic [5:0] COL5 = 6'b110011;
    localparam logic [5:0] COL6 = 6'b010101;
    localparam logic [5:0] COL7 = 6'b101010;
    localparam logic [5:0] BG   = 6'b010000;
    localparam logic [5:0] WHITE = 6'b111111;

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] horCnt, verCnt;
    logic       sActive;
    logic [5:0] rgbContent;

    spin_strip_renderer_if ifc();

    spin_strip_renderer #(
        .STRIP_X0(64), .STRIP_Y0(208), .FAST_STEPS(24), .SLOW_STEPS(8), .PERIOD_MIN(2),
        .BG_COLOR(BG),
        .PALETTE({COL7, COL6, COL5, COL4, COL3, COL2, COL1, COL0})
    ) dut (
        .clk(clk), .reset(reset), .horCnt(horCnt), .verCnt(verCnt),
        .sActive(sActive), .rgbContent(rgbContent), .ctrl(ifc)
    );

    always #5 clk = ~clk;

    typedef struct { logic [5:0] exp; int id; } pixExp_t;
    typedef struct { logic [2:0] res; int ticks; } spinExp_t;
    pixExp_t  pixQ[$];
    spinExp_t spinQ[$];

    int   checks = 0;
    int   errors = 0;
    int   tickCnt = 0;
    logic pixChk = 1'b0;

    function automatic void check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endfunction

    // Monitor: compares registered pixels and spin outcomes after each edge
    always @(posedge clk) begin : monitor
        logic     c, tk, st, bPrev, dPrev;
        pixExp_t  pe;
        spinExp_t se;
        c     = pixChk;
        tk    = (verCnt == 10'd480) && (horCnt == 10'd0);
        st    = ifc.start;
        bPrev = ifc.busy;
        dPrev = ifc.done;
        #1;
        if (c) begin
            if (pixQ.size() == 0) check("pixQueueEmpty", 1, 0);
            else begin
                pe = pixQ.pop_front();
                check($sformatf("pix%0d", pe.id), int'(rgbContent), int'(pe.exp));
            end
        end
        if (reset) begin
            if (st && !bPrev) begin
                check("busyAfterStart", int'(ifc.busy), 1);
                check("doneClearedAfterStart", int'(ifc.done), 0);
            end
            if (ifc.busy && !bPrev) tickCnt = 0;
            else if (tk && bPrev) tickCnt++;
            if (ifc.done && !dPrev) begin
                if (spinQ.size() == 0) check("unexpectedDone", 1, 0);
                else begin
                    se = spinQ.pop_front();
                    check("spinResult", int'(ifc.result), int'(se.res));
                    check("spinTicks", tickCnt, se.ticks);
                    check("busyAtDone", int'(ifc.busy), 0);
                end
            end
        end
    end

    task automatic drive(input logic [9:0] h, input logic [9:0] v, input logic a,
                         input logic chk, input logic [5:0] exp, input int id,
                         input logic st, input logic [2:0] sd);
        @(negedge clk);
        horCnt    = h;
        verCnt    = v;
        sActive   = a;
        pixChk    = chk;
        ifc.start = st;
        if (st) ifc.seed = sd;
        if (chk) pixQ.push_back('{exp, id});
    endtask

    task automatic probe(input logic [9:0] h, input logic [9:0] v, input logic a,
                         input logic [5:0] exp, input int id);
        drive(h, v, a, 1'b1, exp, id, 1'b0, 3'd0);
    endtask

    task automatic idle();
        drive(10'd100, 10'd100, 1'b0, 1'b0, 6'd0, 0, 1'b0, 3'd0);
    endtask

    // One start cycle, then frames of {tick, two visible cycles}.
    // wrapProbes adds cursor-wrap probes and start pulses while busy.
    // abortAt>0 asserts reset asynchronously right after that tick.
    task automatic runSpin(input logic [2:0] sd, input int maxFrames,
                           input logic wrapProbes, input int abortAt);
        bit finished;
        finished = 0;
        drive(10'd100, 10'd100, 1'b0, 1'b0, 6'd0, 0, 1'b1, sd);
        for (int n = 1; n <= maxFrames && !finished; n++) begin
            drive(10'd0, 10'd480, 1'b0, 1'b0, 6'd0, 0, 1'b0, 3'd0);
            if (n == abortAt) begin
                @(negedge clk);
                pixChk = 1'b0;
                #2 reset = 1'b0;
                #1;
                check("abortBusy", int'(ifc.busy), 0);
                check("abortDone", int'(ifc.done), 0);
                check("abortResult", int'(ifc.result), 0);
                check("abortRgb", int'(rgbContent), 0);
                return;
            end
            if (wrapProbes && n == 9) begin
                probe(10'd540, 10'd240, 1'b1, WHITE, 100);
                probe(10'd96, 10'd240, 1'b1, COL0, 101);
            end else if (wrapProbes && n == 10) begin
                probe(10'd540, 10'd240, 1'b1, COL7, 102);
                probe(10'd96, 10'd240, 1'b1, WHITE, 103);
            end else if (wrapProbes && (n == 5 || n == 80)) begin
                idle();
                drive(10'd100, 10'd100, 1'b0, 1'b0, 6'd0, 0, 1'b1, 3'd7);
            end else begin
                idle();
                idle();
            end
            if (ifc.done) finished = 1;
        end
        check("spinCompleted", int'(finished), 1);
    endtask

    initial begin
        reset     = 1'b1;
        horCnt    = '0;
        verCnt    = '0;
        sActive   = 1'b0;
        ifc.start = 1'b0;
        ifc.seed  = '0;
        #2 reset  = 1'b0;
        repeat (3) @(negedge clk);
        check("resetRgb", int'(rgbContent), 0);
        check("resetBusy", int'(ifc.busy), 0);
        check("resetDone", int'(ifc.done), 0);
        check("resetResult", int'(ifc.result), 0);
        reset = 1'b1;

        // Static picture, cursor on tile 0
        probe(10'd64, 10'd208, 1'b1, 6'd0, 1);
        probe(10'd66, 10'd210, 1'b1, WHITE, 2);
        probe(10'd130, 10'd210, 1'b1, COL1, 3);
        probe(10'd10, 10'd10, 1'b1, BG, 4);
        probe(10'd66, 10'd210, 1'b0, 6'd0, 5);
        probe(10'd575, 10'd271, 1'b1, 6'd0, 6);
        probe(10'd574, 10'd270, 1'b1, COL7, 7);
        probe(10'd576, 10'd240, 1'b1, BG, 8);
        probe(10'd63, 10'd240, 1'b1, BG, 9);
        probe(10'd100, 10'd272, 1'b1, BG, 10);
        probe(10'd100, 10'd207, 1'b1, BG, 11);
        probe(10'd300, 10'd260, 1'b1, COL3, 12);
        for (int i = 0; i < 6; i++) probe(10'(i * 150 + 7), 10'(i * 90 + 3), 1'b0, 6'd0, 20 + i);
        idle();

        // 35 steps from cursor 0: 27 fast x 2 + slow 3..10
        spinQ.push_back('{3'd3, 106});
        runSpin(3'd3, 140, 1'b0, 0);
        // 32 steps from cursor 3: 24 fast x 2 + 52
        spinQ.push_back('{3'd3, 100});
        runSpin(3'd0, 140, 1'b0, 0);
        // 37 steps from cursor 3, wrap observed, start pulses ignored
        spinQ.push_back('{3'd0, 110});
        runSpin(3'd5, 140, 1'b1, 0);
        // Aborted spin from cursor 0; would have reached cursor 4 by tick 40
        runSpin(3'd0, 140, 1'b0, 40);
        @(negedge clk);
        reset = 1'b1;
        probe(10'd96, 10'd240, 1'b1, WHITE, 200);
        probe(10'd350, 10'd240, 1'b1, COL4, 201);
        idle();
        @(posedge clk);
        #2;
        check("spinQueueDrained", spinQ.size(), 0);
        check("pixQueueDrained", pixQ.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
